data_mem_access_unit: RTL
=========================

# data_mem_access_unit

Parametrised load/store unit for the pipeline's MEM stage. It owns an inferred synchronous single-port data RAM. Requests arrive on a valid/ready handshake and complete through a held response channel. It supports byte/half/word (and double when WIDTH_B=64) accesses with sign/zero extension, read-modify-write for sub-word stores, and alignment and range error reporting.

## Interface
- WIDTH_B, 32: data word width; 32 or 64 only.
- ADDR_B, 32: byte-address width.
- DEPTH_LOG2, 10: log2 of RAM depth in words.
- Derived OFF_B = log2(WIDTH_B/8): byte-offset bits. Memory span is 2^(DEPTH_LOG2+OFF_B) bytes.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_B  byte address.
- req_size  in  2  access size, 2^req_size bytes.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  WIDTH_B  store data, right-aligned in the low bits.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  WIDTH_B  extended load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned, illegal size or out of range.

## Operation
- Acceptance: req_valid & req_ready at a rising edge latches all req_* fields. Inputs are ignored in every other cycle.
- States:
  - IDLE: accept a request.
  - RD: RAM read.
  - WR: full-word write.
  - MERGE: sub-word write-back.
  - RESP: response held.
- Error check, done at acceptance:
  - Size error: 2^req_size > WIDTH_B/8.
  - Misalignment: req_addr mod 2^req_size != 0.
  - Range error: req_addr >= memory span.
  - On any error: IDLE -> RESP with rsp_err=1 and rsp_rdata=0. No RAM access.
- Transitions:
  - Load: IDLE -> RD -> RESP.
  - Full-width store: IDLE -> WR -> RESP.
  - Sub-word store: IDLE -> RD -> MERGE -> RESP. MERGE replaces bytes [off, off+2^size) of the read word with the low 2^size bytes of req_wdata. All other bytes are kept.
- Word index = req_addr[DEPTH_LOG2+OFF_B-1:OFF_B]; off = req_addr[OFF_B-1:0].
- Load extraction: shift the read word right by 8*off and keep 8*2^size bits. Bits above are filled with copies of the MSB, or with 0 when req_unsigned=1.
- RESP -> IDLE on the edge where rsp_ready=1. rsp_valid, rsp_rdata and rsp_err stay stable for the whole RESP period.
- RAM contents are not reset and are undefined at power-up.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset during RD, WR or MERGE abandons the access. A RAM write is committed only if the WR or MERGE edge completed before rst_n fell.
- Latency from acceptance (cycle 0) to rsp_valid:
  - Load and full store: rsp_valid high in cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- Throughput: the next acceptance can happen in the cycle after the rsp_ready handshake. There is no overlap of requests.
- rsp_valid never drops without rsp_ready. req_ready=0 from the acceptance edge until RESP exits.
- rsp_ready asserted while rsp_valid=0 has no effect.
- A load issued after a store's response returns the stored data; there is no read-during-write hazard.

## Test plan
- Word store then load at WIDTH_B=32, DEPTH_LOG2=10: store 0xDEADBEEF at 0x10, rsp at cycle 2 with rsp_err=0. Load word at 0x10 -> rsp_rdata=0xDEADBEEF at cycle 2.
- Sub-word store and extended loads: store byte 0xAA at 0x11 over 0xDEADBEEF -> rsp at cycle 3; a word load then returns 0xDEADAAEF. Signed byte load at 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA. Signed half load at 0x12 -> 0xFFFFDEAD.
- Misaligned half load at 0x13 -> rsp_err=1, rsp_rdata=0 at cycle 1. A word store to 0x1000 (out of range) -> rsp_err=1. Illegal size 3 at WIDTH_B=32 -> rsp_err=1. In all three cases RAM is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load response while pulsing req_valid -> rsp_valid/rsp_rdata stay stable, req_ready=0, and no request is taken. Releasing rsp_ready gives req_ready=1 on the next cycle.
- Reset mid-access: assert rst_n=0 during RD of a byte store to 0x20 (word 0x11223344) -> outputs go to reset values immediately. A later word load at 0x20 returns 0x11223344.
- WIDTH_B=64 build: store double 0x0123456789ABCDEF at 0x8, then signed word load at 0xC -> 0x0000000001234567, and signed byte load at 0xF -> 0x0000000000000001.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// Load/store unit for the MEM stage: owns a synchronous single-port data RAM,
// does sub-word read-modify-write, sign/zero extension and access error checks.
module data_mem_access_unit #(
  parameter int unsigned WIDTH_B    = 32,
  parameter int unsigned ADDR_B     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_B-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WIDTH_B-1:0]    req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH_B-1:0]    rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned NBYTES = WIDTH_B / 8;
  localparam int unsigned OFF_B  = $clog2(NBYTES);
  localparam int unsigned SPAN_B = DEPTH_LOG2 + OFF_B;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    MERGE,
    RESP
  } state_t;

  typedef struct packed {
    logic                  is_write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [OFF_B-1:0]      off;
    logic [1:0]            size;
    logic                  uns;
    logic [WIDTH_B-1:0]    wdata;
  } req_t;

  state_t               state;
  req_t                 lat;
  logic [WIDTH_B-1:0]   mem [DEPTH];
  logic [WIDTH_B-1:0]   rd_word;

  logic                  accept_c;
  logic                  size_err_c;
  logic                  misalign_c;
  logic                  range_err_c;
  logic                  full_c;
  logic [ADDR_B-1:0]     align_mask_c;
  logic [DEPTH_LOG2-1:0] req_idx_c;
  logic [OFF_B-1:0]      req_off_c;
  logic [WIDTH_B-1:0]    rd_shift_c;
  logic [WIDTH_B-1:0]    keep_c;
  logic                  sign_c;
  logic [WIDTH_B-1:0]    load_c;
  logic [WIDTH_B-1:0]    mask_c;
  logic [WIDTH_B-1:0]    merge_c;

  // Request decode and error checks, evaluated on the raw request fields.
  always_comb begin
    accept_c     = req_valid & req_ready;
    size_err_c   = (32'(1) << req_size) > NBYTES;
    full_c       = (32'(1) << req_size) == NBYTES;
    align_mask_c = ADDR_B'((32'(1) << req_size) - 32'(1));
    misalign_c   = |(req_addr & align_mask_c);
    range_err_c  = |(req_addr >> SPAN_B);
    req_idx_c    = req_addr[SPAN_B-1:OFF_B];
    req_off_c    = req_addr[OFF_B-1:0];
  end

  // Lane selection: keep_c covers the low 2^size bytes; shifted by off it
  // becomes the byte-enable mask for the merge.
  always_comb begin
    rd_shift_c = rd_word >> {lat.off, 3'b000};
    keep_c     = '1;
    sign_c     = rd_shift_c[WIDTH_B-1];
    case (lat.size)
      2'd0: begin
        keep_c = WIDTH_B'(8'hFF);
        sign_c = rd_shift_c[7];
      end
      2'd1: begin
        keep_c = WIDTH_B'(16'hFFFF);
        sign_c = rd_shift_c[15];
      end
      2'd2: begin
        keep_c = WIDTH_B'(32'hFFFF_FFFF);
        sign_c = rd_shift_c[31];
      end
      default: begin
        keep_c = '1;
        sign_c = rd_shift_c[WIDTH_B-1];
      end
    endcase
    load_c  = (rd_shift_c & keep_c) | ({WIDTH_B{sign_c & ~lat.uns}} & ~keep_c);
    mask_c  = keep_c << {lat.off, 3'b000};
    merge_c = ((lat.wdata << {lat.off, 3'b000}) & mask_c) | (rd_word & ~mask_c);
  end

  // RAM: read on acceptance so the word is ready during RD; writes gated by
  // state so a reset that returns to IDLE abandons a pending write.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      rd_word <= mem[req_idx_c];
    end
    if (state == WR) begin
      mem[lat.idx] <= lat.wdata;
    end else if (state == MERGE) begin
      mem[lat.idx] <= merge_c;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            lat.is_write <= req_write;
            lat.idx      <= req_idx_c;
            lat.off      <= req_off_c;
            lat.size     <= req_size;
            lat.uns      <= req_unsigned;
            lat.wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (size_err_c || misalign_c || range_err_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_write && full_c) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (lat.is_write) begin
            state <= MERGE;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_c;
          end
        end
        WR, MERGE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
